// File: rtl/vdp_slot_io_bridge_if.sv
// VRAM request/response channel between the slot I/O bridge and the SDRAM-side arbiter.
interface vdp_slot_io_bridge_if;
  logic        vram_valid;
  logic        vram_write;
  logic [16:0] vram_address;
  logic [7:0]  vram_wdata;
  logic        vram_ready;
  logic        vram_rdata_en;
  logic [7:0]  vram_rdata;

  modport master (
    output vram_valid, vram_write, vram_address, vram_wdata,
    input  vram_ready, vram_rdata_en, vram_rdata
  );

  modport slave (
    input  vram_valid, vram_write, vram_address, vram_wdata,
    output vram_ready, vram_rdata_en, vram_rdata
  );
endinterface

// File: rtl/vdp_slot_io_bridge.sv
// MSX slot front end implementing the V99x8 four-port I/O protocol.
// Define VDP_INDIRECT_REG_EN to enable port 3 and the R#17 shadow.
module vdp_slot_io_bridge #(
  parameter logic [7:0] IO_BASE = 8'h88
) (
  input  logic        clk14m,
  input  logic        slot_reset_n,
  input  logic        slot_iorq_n,
  input  logic        slot_rd_n,
  input  logic        slot_wr_n,
  input  logic [7:0]  slot_a,
  inout  wire  [7:0]  slot_d,
  output logic        slot_data_dir,
  output logic        busdir,
  output logic        oe_n,
  output logic        slot_wait,
  output logic        slot_intr,
  input  logic        init_busy,
  input  logic        int_req,
  input  logic [7:0]  status_data,
  output logic        status_rd,
  output logic        reg_wr,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_data,
  output logic        pal_wr,
  output logic [3:0]  pal_num,
  output logic [8:0]  pal_data,
  vdp_slot_io_bridge_if.master vram
);

  logic [1:0]  iorq_s, rd_s, wr_s;
  logic        wr_cyc_q, rd_cyc_q;
  logic        wr_cyc, rd_cyc, wr_det, rd_det;
  logic [7:0]  a_off;
  logic        hit;
  logic [1:0]  port;

  logic [16:0] ptr, ptr_nx, ld_ptr, req_addr;
  logic        first_flag, first_nx;
  logic [7:0]  lat, lat_nx, rbuf, dout;
  logic        pal_first, palf_nx;
  logic [5:0]  pal_lat, pal_lat_nx;
  logic [2:0]  r14;
  logic [3:0]  r16;
  logic        req_go, req_write, rw_go, pw_go, st_go;
  logic [5:0]  rw_num;
  logic [7:0]  rw_data;
`ifdef VDP_INDIRECT_REG_EN
  logic [7:0]  r17;
  logic        ind_go;
`endif

  logic        v_valid, v_write, p_valid, p_write;
  logic [16:0] v_addr, p_addr;
  logic [7:0]  v_wdata, p_wdata;

  always_ff @(posedge clk14m or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      iorq_s   <= '1;
      rd_s     <= '1;
      wr_s     <= '1;
      wr_cyc_q <= 1'b1;
      rd_cyc_q <= 1'b1;
    end else begin
      iorq_s   <= {iorq_s[0], slot_iorq_n};
      rd_s     <= {rd_s[0], slot_rd_n};
      wr_s     <= {wr_s[0], slot_wr_n};
      wr_cyc_q <= wr_cyc;
      rd_cyc_q <= rd_cyc;
    end
  end

  assign wr_cyc = iorq_s[1] | wr_s[1];
  assign rd_cyc = iorq_s[1] | rd_s[1];
  assign wr_det = wr_cyc_q & ~wr_cyc;
  assign rd_det = rd_cyc_q & ~rd_cyc;
  assign a_off  = slot_a - IO_BASE;
  assign hit    = (a_off[7:2] == 6'd0);
  assign port   = a_off[1:0];
  assign ld_ptr = {r14, slot_d[5:0], lat};

  always_comb begin
    req_go     = 1'b0;
    req_write  = 1'b0;
    req_addr   = ptr;
    rw_go      = 1'b0;
    rw_num     = slot_d[5:0];
    rw_data    = lat;
    pw_go      = 1'b0;
    st_go      = 1'b0;
    ptr_nx     = ptr;
    first_nx   = first_flag;
    lat_nx     = lat;
    palf_nx    = pal_first;
    pal_lat_nx = pal_lat;
`ifdef VDP_INDIRECT_REG_EN
    ind_go     = 1'b0;
`endif
    if (wr_det && hit) begin
      unique case (port)
        2'd0: begin
          req_go    = 1'b1;
          req_write = 1'b1;
          ptr_nx    = ptr + 17'd1;
          first_nx  = 1'b0;
        end
        2'd1: begin
          if (!first_flag) begin
            lat_nx   = slot_d;
            first_nx = 1'b1;
          end else begin
            first_nx = 1'b0;
            if (slot_d[7]) begin
              rw_go = 1'b1;
            end else begin
              // D[6]=0 loads the pointer and prefetches from it in one go
              req_addr = ld_ptr;
              ptr_nx   = ld_ptr;
              if (!slot_d[6]) begin
                req_go = 1'b1;
                ptr_nx = ld_ptr + 17'd1;
              end
            end
          end
        end
        2'd2: begin
          if (!pal_first) begin
            pal_lat_nx = {slot_d[6:4], slot_d[2:0]};
            palf_nx    = 1'b1;
          end else begin
            palf_nx = 1'b0;
            pw_go   = 1'b1;
          end
        end
        2'd3: begin
`ifdef VDP_INDIRECT_REG_EN
          if (r17[5:0] != 6'd17) begin
            rw_go   = 1'b1;
            ind_go  = 1'b1;
            rw_num  = r17[5:0];
            rw_data = slot_d;
          end
`endif
        end
      endcase
    end else if (rd_det && hit) begin
      if (port == 2'd0) begin
        req_go   = 1'b1;
        ptr_nx   = ptr + 17'd1;
        first_nx = 1'b0;
      end else if (port == 2'd1) begin
        st_go    = 1'b1;
        first_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk14m or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      ptr        <= '0;
      first_flag <= 1'b0;
      lat        <= '0;
      pal_first  <= 1'b0;
      pal_lat    <= '0;
      r14        <= '0;
      r16        <= '0;
      rbuf       <= '0;
      reg_wr     <= 1'b0;
      reg_num    <= '0;
      reg_data   <= '0;
      pal_wr     <= 1'b0;
      pal_num    <= '0;
      pal_data   <= '0;
      status_rd  <= 1'b0;
`ifdef VDP_INDIRECT_REG_EN
      r17        <= '0;
`endif
    end else begin
      ptr        <= ptr_nx;
      first_flag <= first_nx;
      lat        <= lat_nx;
      pal_first  <= palf_nx;
      pal_lat    <= pal_lat_nx;
      reg_wr     <= rw_go;
      pal_wr     <= pw_go;
      status_rd  <= st_go;
      if (rw_go) begin
        reg_num  <= rw_num;
        reg_data <= rw_data;
        if (rw_num == 6'd14) r14 <= rw_data[2:0];
        // Selecting a palette entry restarts the two-byte palette sequence
        if (rw_num == 6'd16) begin
          r16       <= rw_data[3:0];
          pal_first <= 1'b0;
        end
`ifdef VDP_INDIRECT_REG_EN
        if (rw_num == 6'd17) r17 <= rw_data;
        if (ind_go && !r17[7]) r17[5:0] <= r17[5:0] + 6'd1;
`endif
      end
      if (pw_go) begin
        pal_num  <= r16;
        pal_data <= {pal_lat, slot_d[2:0]};
        r16      <= r16 + 4'd1;
      end
      if (vram.vram_rdata_en) rbuf <= vram.vram_rdata;
    end
  end

  // One-deep queue: a port-0 access during an outstanding request waits here
  always_ff @(posedge clk14m or negedge slot_reset_n) begin
    if (!slot_reset_n) begin
      v_valid <= 1'b0;
      v_write <= 1'b0;
      v_addr  <= '0;
      v_wdata <= '0;
      p_valid <= 1'b0;
      p_write <= 1'b0;
      p_addr  <= '0;
      p_wdata <= '0;
    end else if (!v_valid || vram.vram_ready) begin
      if (p_valid) begin
        v_valid <= 1'b1;
        v_write <= p_write;
        v_addr  <= p_addr;
        v_wdata <= p_wdata;
        p_valid <= req_go;
        p_write <= req_write;
        p_addr  <= req_addr;
        p_wdata <= slot_d;
      end else begin
        v_valid <= req_go;
        if (req_go) begin
          v_write <= req_write;
          v_addr  <= req_addr;
          v_wdata <= slot_d;
        end
      end
    end else if (req_go) begin
      p_valid <= 1'b1;
      p_write <= req_write;
      p_addr  <= req_addr;
      p_wdata <= slot_d;
    end
  end

  assign vram.vram_valid   = v_valid;
  assign vram.vram_write   = v_write;
  assign vram.vram_address = v_addr;
  assign vram.vram_wdata   = v_wdata;

  always_comb begin
    dout = '1;
    if (port == 2'd0)      dout = rbuf;
    else if (port == 2'd1) dout = status_data;
  end

  assign slot_data_dir = ~slot_iorq_n & ~slot_rd_n & hit;
  assign busdir        = slot_data_dir;
  assign slot_d        = slot_data_dir ? dout : 8'hzz;
  assign oe_n          = 1'b0;
  assign slot_wait     = init_busy | v_valid;
  assign slot_intr     = int_req;

endmodule

// File: tb/tb_vdp_slot_io_bridge.sv
// Directed scoreboard bench for vdp_slot_io_bridge: Z80 I/O cycles in, strobes and VRAM requests checked.
module tb_vdp_slot_io_bridge;
  logic        clk14m = 1'b0;
  logic        slot_reset_n = 1'b0;
  logic        slot_iorq_n = 1'b1, slot_rd_n = 1'b1, slot_wr_n = 1'b1;
  logic [7:0]  slot_a = 8'h00;
  wire  [7:0]  slot_d;
  logic        tb_den = 1'b0;
  logic [7:0]  tb_dval = 8'h00;
  logic        slot_data_dir, busdir, oe_n, slot_wait, slot_intr;
  logic        init_busy = 1'b1, int_req = 1'b0;
  logic [7:0]  status_data = 8'h9C;
  logic        status_rd, reg_wr, pal_wr;
  logic [5:0]  reg_num;
  logic [7:0]  reg_data;
  logic [3:0]  pal_num;
  logic [8:0]  pal_data;
  logic        tb_ready = 1'b1;
  logic [7:0]  tb_rdval = 8'h00;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] q_reg[$], q_pal[$], q_vram[$], q_stat[$];
  logic [31:0] mon_e;

  vdp_slot_io_bridge_if vif();

  vdp_slot_io_bridge #(.IO_BASE(8'h88)) dut (
    .clk14m        (clk14m),
    .slot_reset_n  (slot_reset_n),
    .slot_iorq_n   (slot_iorq_n),
    .slot_rd_n     (slot_rd_n),
    .slot_wr_n     (slot_wr_n),
    .slot_a        (slot_a),
    .slot_d        (slot_d),
    .slot_data_dir (slot_data_dir),
    .busdir        (busdir),
    .oe_n          (oe_n),
    .slot_wait     (slot_wait),
    .slot_intr     (slot_intr),
    .init_busy     (init_busy),
    .int_req       (int_req),
    .status_data   (status_data),
    .status_rd     (status_rd),
    .reg_wr        (reg_wr),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .pal_wr        (pal_wr),
    .pal_num       (pal_num),
    .pal_data      (pal_data),
    .vram          (vif)
  );

  assign slot_d = tb_den ? tb_dval : 8'hzz;
  assign vif.vram_ready = tb_ready;

  always #6 clk14m = ~clk14m;

  // VRAM side: read data returns the cycle after a read request is accepted
  always @(posedge clk14m) begin
    vif.vram_rdata_en <= vif.vram_valid & vif.vram_ready & ~vif.vram_write;
    vif.vram_rdata    <= tb_rdval;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev_reg(input logic [5:0] n, input logic [7:0] d);
    return {18'd0, n, d};
  endfunction
  function automatic logic [31:0] ev_pal(input logic [3:0] n, input logic [8:0] d);
    return {19'd0, n, d};
  endfunction
  function automatic logic [31:0] ev_vw(input logic [16:0] a, input logic [7:0] d);
    return {6'd0, 1'b1, a, d};
  endfunction
  function automatic logic [31:0] ev_vr(input logic [16:0] a);
    return {6'd0, 1'b0, a, 8'h00};
  endfunction

  always @(negedge clk14m) begin
    if (reg_wr) begin
      mon_e = (q_reg.size() != 0) ? q_reg.pop_front() : '1;
      check("reg_wr", {18'd0, reg_num, reg_data}, mon_e);
    end
    if (pal_wr) begin
      mon_e = (q_pal.size() != 0) ? q_pal.pop_front() : '1;
      check("pal_wr", {19'd0, pal_num, pal_data}, mon_e);
    end
    if (status_rd) begin
      mon_e = (q_stat.size() != 0) ? q_stat.pop_front() : '1;
      check("status_rd", {24'd0, status_data}, mon_e);
    end
    if (vif.vram_valid && vif.vram_ready) begin
      mon_e = (q_vram.size() != 0) ? q_vram.pop_front() : '1;
      check("vram_req", {6'd0, vif.vram_write, vif.vram_address,
                         vif.vram_write ? vif.vram_wdata : 8'h00}, mon_e);
    end
  end

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d, input bit timed = 1'b0);
    @(negedge clk14m);
    slot_a = a; tb_dval = d; tb_den = 1'b1;
    slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    if (timed) begin
      repeat (2) @(posedge clk14m);
      #1 check("strobe_early", reg_wr, 0);
      @(posedge clk14m);
      #1 check("strobe_cycle3", reg_wr, 1);
      @(posedge clk14m);
      #1 check("strobe_width", reg_wr, 0);
    end
    repeat (6) @(negedge clk14m);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1; tb_den = 1'b0;
    repeat (2) @(negedge clk14m);
  endtask

  task automatic io_rd(input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk14m);
    slot_a = a; slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
    repeat (2) @(negedge clk14m);
    check("rd_dir", slot_data_dir, 1);
    check("rd_busdir", busdir, 1);
    check("rd_data", slot_d, exp);
    repeat (5) @(negedge clk14m);
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1;
    @(negedge clk14m);
    check("rd_release", slot_data_dir, 0);
    repeat (2) @(negedge clk14m);
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n = 0;
    while ((q_reg.size() + q_pal.size() + q_vram.size() + q_stat.size()) != 0 && n < 60) begin
      @(negedge clk14m);
      n++;
    end
    check(tag, 32'(q_reg.size() + q_pal.size() + q_vram.size() + q_stat.size()), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk14m);
    check("rst_wait", slot_wait, 1);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_pal_wr", pal_wr, 0);
    check("rst_status_rd", status_rd, 0);
    check("rst_vram_valid", vif.vram_valid, 0);
    check("rst_data_dir", slot_data_dir, 0);
    check("rst_busdir", busdir, 0);
    check("rst_oe_n", oe_n, 0);
    slot_reset_n = 1'b1;
    repeat (2) @(negedge clk14m);
    check("busy_wait", slot_wait, 1);
    int_req = 1'b1;
    #1 check("intr_follow", slot_intr, 1);
    int_req = 1'b0;
    init_busy = 1'b0;
    @(negedge clk14m);
    check("idle_wait", slot_wait, 0);

    // register writes through the two-byte latch
    q_reg.push_back(ev_reg(6'd1, 8'h43));
    io_wr(8'h89, 8'h43);
    io_wr(8'h89, 8'h81, 1'b1);
    q_reg.push_back(ev_reg(6'd2, 8'h06));
    io_wr(8'h89, 8'h06);
    io_wr(8'h89, 8'h82);
    wait_drain("drain_reg");

    // sequential VRAM writes from pointer 0
    for (int i = 0; i < 3; i++) q_vram.push_back(ev_vw(17'(i), 8'(i)));
    io_wr(8'h89, 8'h00);
    io_wr(8'h89, 8'h40);
    for (int i = 0; i < 3; i++) io_wr(8'h88, 8'(i));
    wait_drain("drain_vw0");

    for (int i = 0; i < 4; i++) q_vram.push_back(ev_vw(17'h01B00 + 17'(i), 8'hA0 + 8'(i)));
    io_wr(8'h89, 8'h00);
    io_wr(8'h89, 8'h5B);
    for (int i = 0; i < 4; i++) io_wr(8'h88, 8'hA0 + 8'(i));
    wait_drain("drain_vw1b");

    // pointer wrap at the top of the 128K space
    q_reg.push_back(ev_reg(6'd14, 8'h07));
    io_wr(8'h89, 8'h07);
    io_wr(8'h89, 8'h8E);
    q_vram.push_back(ev_vw(17'h1FFFF, 8'h55));
    q_vram.push_back(ev_vw(17'h00000, 8'h66));
    io_wr(8'h89, 8'hFF);
    io_wr(8'h89, 8'h7F);
    io_wr(8'h88, 8'h55);
    io_wr(8'h88, 8'h66);
    q_reg.push_back(ev_reg(6'd14, 8'h00));
    io_wr(8'h89, 8'h00);
    io_wr(8'h89, 8'h8E);
    wait_drain("drain_wrap");

    // read setup prefetch, then reads return prefetched data
    tb_rdval = 8'hA5;
    q_vram.push_back(ev_vr(17'h00010));
    io_wr(8'h89, 8'h10);
    io_wr(8'h89, 8'h00);
    wait_drain("drain_rdsetup");
    tb_rdval = 8'h3C;
    q_vram.push_back(ev_vr(17'h00011));
    io_rd(8'h88, 8'hA5);
    wait_drain("drain_rd1");
    q_vram.push_back(ev_vr(17'h00012));
    io_rd(8'h88, 8'h3C);
    wait_drain("drain_rd2");

    // status read, and status read resetting the latch sequence
    q_stat.push_back(32'h9C);
    io_rd(8'h89, 8'h9C);
    io_wr(8'h89, 8'h12);
    q_stat.push_back(32'h9C);
    io_rd(8'h89, 8'h9C);
    q_reg.push_back(ev_reg(6'd5, 8'h34));
    io_wr(8'h89, 8'h34);
    io_wr(8'h89, 8'h85);
    wait_drain("drain_status");

    // addresses outside the decoded window
    io_wr(8'h98, 8'h11);
    io_wr(8'h87, 8'h11);
    io_wr(8'h8C, 8'h11);
    wait_drain("drain_nohit");
    check("nohit_valid", vif.vram_valid, 0);

    // palette writes with auto-incrementing index
    q_pal.push_back(ev_pal(4'd0, 9'h1FF));
    io_wr(8'h8A, 8'h77);
    io_wr(8'h8A, 8'h07);
    q_pal.push_back(ev_pal(4'd1, 9'h0AB));
    io_wr(8'h8A, 8'h25);
    io_wr(8'h8A, 8'h03);
    io_rd(8'h8A, 8'hFF);
    wait_drain("drain_pal");

    // indirect register port
`ifdef VDP_INDIRECT_REG_EN
    q_reg.push_back(ev_reg(6'd0, 8'h5A));
`endif
    io_wr(8'h8B, 8'h5A);
    io_rd(8'h8B, 8'hFF);
    wait_drain("drain_port3");

    // second access queued while the first request is still outstanding
    tb_ready = 1'b0;
    q_vram.push_back(ev_vw(17'h00000, 8'h11));
    q_vram.push_back(ev_vw(17'h00001, 8'h22));
    io_wr(8'h89, 8'h00);
    io_wr(8'h89, 8'h40);
    io_wr(8'h88, 8'h11);
    io_wr(8'h88, 8'h22);
    check("hold_valid", vif.vram_valid, 1);
    check("hold_addr", vif.vram_address, 32'h0);
    check("hold_wdata", vif.vram_wdata, 32'h11);
    check("hold_wait", slot_wait, 1);
    tb_ready = 1'b1;
    wait_drain("drain_pending");

    // reset while a request is outstanding
    tb_ready = 1'b0;
    io_wr(8'h88, 8'h33);
    check("pre_rst_valid", vif.vram_valid, 1);
    @(negedge clk14m);
    #3 slot_reset_n = 1'b0;
    #1 check("midrst_valid", vif.vram_valid, 0);
    check("midrst_wait", slot_wait, 0);
    repeat (2) @(negedge clk14m);
    slot_reset_n = 1'b1;
    tb_ready = 1'b1;
    repeat (5) @(negedge clk14m);
    check("postrst_valid", vif.vram_valid, 0);
    q_vram.push_back(ev_vw(17'h00000, 8'h77));
    io_wr(8'h88, 8'h77);
    q_vram.push_back(ev_vr(17'h00001));
    io_rd(8'h88, 8'h00);
    wait_drain("drain_postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end
endmodule
